// File: rtl/vx_dispatch_batcher.sv
// vx_dispatch_batcher: routes each issued instruction to one execution unit and
// splits its NUM_THREADS-wide operand vector into NUM_LANES-wide batches.
// Each unit owns an elastic buffer of BUF_SIZE entries.
// Optional feature macro: DISPATCH_BATCH_SKIP_EN. When defined, batches whose
// thread-mask slice is all-zero are not emitted.
module vx_dispatch_batcher #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 4,
    parameter int DATAW       = 32,
    parameter int HDRW        = 64,
    parameter int BUF_SIZE    = 2,
    localparam int NB = NUM_THREADS / NUM_LANES,
    localparam int BW = (NB > 1) ? $clog2(NB) : 1,
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [UW-1:0]                      in_unit,
    input  logic [NUM_THREADS-1:0]             in_tmask,
    input  logic [NUM_THREADS*DATAW-1:0]       in_data,
    input  logic [HDRW-1:0]                    in_hdr,
    output logic [NUM_UNITS-1:0]               out_valid,
    input  logic [NUM_UNITS-1:0]               out_ready,
    output logic [NUM_UNITS*NUM_LANES-1:0]     out_tmask,
    output logic [NUM_UNITS*NUM_LANES*DATAW-1:0] out_data,
    output logic [NUM_UNITS*HDRW-1:0]          out_hdr,
    output logic [NUM_UNITS*BW-1:0]            out_pid,
    output logic [NUM_UNITS-1:0]               out_sop,
    output logic [NUM_UNITS-1:0]               out_eop,
    output logic [NUM_UNITS*TW-1:0]            out_last_tid,
    output logic                               err_bad_unit
);

    localparam int PW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam int CW = $clog2(BUF_SIZE + 1);

    typedef struct packed {
        logic [NUM_LANES-1:0]       tmask;
        logic [NUM_LANES*DATAW-1:0] data;
        logic [HDRW-1:0]            hdr;
        logic [BW-1:0]              pid;
        logic                       sop;
        logic                       eop;
        logic [TW-1:0]              last_tid;
    } entry_t;

    logic [BW-1:0]        batch_idx;
    logic [BW-1:0]        cur_b;
    logic [BW-1:0]        first_b;
    logic [BW-1:0]        last_b;
    logic [TW-1:0]        last_tid;
    logic [31:0]          unit_ext;
    logic                 bad_unit;
    logic                 sel_can_push;
    logic [NUM_UNITS-1:0] can_push;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    entry_t               push_entry;

    entry_t               mem   [NUM_UNITS][BUF_SIZE];
    logic [PW-1:0]        head  [NUM_UNITS];
    logic [PW-1:0]        tail  [NUM_UNITS];
    logic [CW-1:0]        count [NUM_UNITS];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (int'(p) == BUF_SIZE - 1) ? '0 : p + PW'(1);
    endfunction

    assign unit_ext = 32'(in_unit);
    assign bad_unit = in_valid && (unit_ext >= 32'(NUM_UNITS));

    // Highest active thread of the whole instruction (0 for an empty mask).
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        last_tid = '0;
        for (int t = 0; t < NUM_THREADS; t++)
            if (in_tmask[t]) last_tid = TW'(t);
    end

`ifdef DISPATCH_BATCH_SKIP_EN
    logic [NB-1:0] slice_nz;

    // Pick the batch to emit now: next non-empty slice at or after batch_idx.
    always_comb begin
        slice_nz = '0;
        for (int b = 0; b < NB; b++)
            slice_nz[b] = |in_tmask[b*NUM_LANES +: NUM_LANES];
        first_b = '0;
        last_b  = '0;
        cur_b   = batch_idx;
        for (int b = NB - 1; b >= 0; b--)
            if (slice_nz[b]) first_b = BW'(b);
        for (int b = 0; b < NB; b++)
            if (slice_nz[b]) last_b = BW'(b);
        for (int b = NB - 1; b >= 0; b--)
            if (slice_nz[b] && b >= int'(batch_idx)) cur_b = BW'(b);
    end
`else
    // Every batch is emitted in order, empty ones included.
    always_comb begin
        first_b = '0;
        last_b  = BW'(NB - 1);
        cur_b   = batch_idx;
    end
`endif

    // Assemble the batch entry for the currently selected slice.
    always_comb begin
        push_entry.tmask    = in_tmask[int'(cur_b)*NUM_LANES +: NUM_LANES];
        push_entry.data     = in_data[int'(cur_b)*NUM_LANES*DATAW +: NUM_LANES*DATAW];
        push_entry.hdr      = in_hdr;
        push_entry.pid      = cur_b;
        push_entry.sop      = (cur_b == first_b);
        push_entry.eop      = (cur_b == last_b);
        push_entry.last_tid = last_tid;
    end

    // Per-unit push/pop handshakes; a full buffer may still accept while popping.
    always_comb begin
        push         = '0;
        pop          = '0;
        can_push     = '0;
        sel_can_push = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            pop[u]      = (count[u] != '0) && out_ready[u];
            can_push[u] = (count[u] < CW'(BUF_SIZE)) || pop[u];
            if (unit_ext == 32'(u)) sel_can_push = can_push[u];
            push[u]     = in_valid && !bad_unit && (unit_ext == 32'(u)) && can_push[u];
        end
    end

    assign in_ready = in_valid && (bad_unit || (sel_can_push && (cur_b == last_b)));

    // Batch counter and sticky bad-unit flag.
    // NOTE: sequential state is updated with non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            batch_idx    <= '0;
            err_bad_unit <= 1'b0;
        end else begin
            if (bad_unit) err_bad_unit <= 1'b1;
            if (in_valid && !bad_unit && sel_can_push)
                batch_idx <= (cur_b == last_b) ? '0 : cur_b + BW'(1);
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                head[u]  <= '0;
                tail[u]  <= '0;
                count[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (push[u]) tail[u] <= next_ptr(tail[u]);
                if (pop[u])  head[u] <= next_ptr(head[u]);
                if (push[u] && !pop[u])      count[u] <= count[u] + CW'(1);
                else if (!push[u] && pop[u]) count[u] <= count[u] - CW'(1);
            end
        end
    end

    // Buffer storage.
    // NOTE: storage has no reset; outputs are forced to zero while a buffer is empty, so stale contents never escape.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++)
            if (push[u]) mem[u][tail[u]] <= push_entry;
    end

    // Present each buffer head, zeroed when the buffer is empty.
    always_comb begin
        out_valid    = '0;
        out_tmask    = '0;
        out_data     = '0;
        out_hdr      = '0;
        out_pid      = '0;
        out_sop      = '0;
        out_eop      = '0;
        out_last_tid = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            out_valid[u] = (count[u] != '0);
            if (out_valid[u]) begin
                out_tmask[u*NUM_LANES +: NUM_LANES]             = mem[u][head[u]].tmask;
                out_data[u*NUM_LANES*DATAW +: NUM_LANES*DATAW]  = mem[u][head[u]].data;
                out_hdr[u*HDRW +: HDRW]                         = mem[u][head[u]].hdr;
                out_pid[u*BW +: BW]                             = mem[u][head[u]].pid;
                out_sop[u]                                      = mem[u][head[u]].sop;
                out_eop[u]                                      = mem[u][head[u]].eop;
                out_last_tid[u*TW +: TW]                        = mem[u][head[u]].last_tid;
            end
        end
    end

endmodule

// File: doc/vx_dispatch_batcher.md
Name: vx_dispatch_batcher

Overview:
- Parametrised dispatch stage between operand collection and the execution units.
- Routes each issued instruction to one of NUM_UNITS execution units and splits its NUM_THREADS-wide operand vector into NUM_LANES-wide batches, so units narrower than the warp can be used.
- Each unit has its own elastic buffer of depth BUF_SIZE.
- Each batch carries start/end-of-packet flags, a batch index and the last active thread id of the whole instruction.

Parameters:
- NUM_UNITS, 4, number of execution-unit output channels.
- NUM_THREADS, 8, threads per warp; power of two.
- NUM_LANES, 4, lanes per unit; power of two; must divide NUM_THREADS.
- DATAW, 32, per-thread operand payload bits.
- HDRW, 64, per-instruction header bits (uuid, wid, PC, op, rd, ...), passed through unchanged.
- BUF_SIZE, 2, per-unit buffer depth; minimum 1.
- Derived: NB = NUM_THREADS/NUM_LANES; BW = max(1, log2(NB)); UW = max(1, log2(NUM_UNITS)); TW = max(1, log2(NUM_THREADS)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction consumed; high only in the cycle its final batch is accepted.
- in_unit  in  UW  target unit index.
- in_tmask  in  NUM_THREADS  thread mask.
- in_data  in  NUM_THREADS*DATAW  per-thread operands.
- in_hdr  in  HDRW  header.
- out_valid  out  NUM_UNITS  per-unit batch valid.
- out_ready  in  NUM_UNITS  per-unit accept.
- out_tmask  out  NUM_UNITS*NUM_LANES  batch lane mask.
- out_data  out  NUM_UNITS*NUM_LANES*DATAW  batch operands.
- out_hdr  out  NUM_UNITS*HDRW  header copy.
- out_pid  out  NUM_UNITS*BW  batch index.
- out_sop  out  NUM_UNITS  first batch of instruction.
- out_eop  out  NUM_UNITS  last batch of instruction.
- out_last_tid  out  NUM_UNITS*TW  highest set bit index of the full in_tmask; 0 if the mask is empty.
- err_bad_unit  out  1  sticky; set when in_unit >= NUM_UNITS.

Behaviour:
- Reset (reset=0, asynchronous):
  - batch_idx=0.
  - All buffers empty: out_valid=0; out_tmask/data/hdr/pid/sop/eop/last_tid=0.
  - err_bad_unit=0.
  - Reset mid-packet discards the partial instruction; on release the same in_* is restarted from batch 0.
- Batch counter batch_idx (BW bits) selects threads [batch_idx*NUM_LANES +: NUM_LANES].
- Batch push:
  - A batch is pushed into unit in_unit's buffer when in_valid && buffer not full.
  - Push with batch_idx != last: batch_idx++ and in_ready=0.
  - Push with batch_idx == last: batch_idx wraps to 0 and in_ready=1, same cycle, combinational from buffer-not-full.
- Inputs in_* must stay stable while in_valid=1 and in_ready=0. A bench assertion flags any change.
- sop = (batch_idx == first emitted batch); eop = (batch_idx == last emitted batch).
- NB=1 (NUM_LANES == NUM_THREADS): every instruction is one batch with sop=eop=1 and pid=0; in_ready equals the target buffer not-full.
- Buffer:
  - Registered output; first batch appears on out_* one cycle after push (latency 1).
  - Sustains one push and one pop per cycle when full and popping.
  - Full: no push, batch_idx holds.
  - Empty: out_valid=0.
- Only the selected unit's buffer is written. The other units drain independently, with no head-of-line coupling except via in_ready.
- in_unit >= NUM_UNITS: instruction dropped (in_ready=1 the same cycle), err_bad_unit set until reset.
- in_valid=0: batch_idx holds (only 0 is legal at this point).

Optional Feature:
- Macro: DISPATCH_BATCH_SKIP_EN.
- Defined: batches whose tmask slice is all-zero are not emitted.
  - batch_idx advances to the next batch with a nonzero slice in a single cycle, without a push.
  - sop/eop mark the first/last nonzero batch.
  - An all-zero in_tmask emits exactly one batch (batch 0) with sop=eop=1.
- Undefined: all NB batches are always emitted, including empty ones.

Test Plan:
- Setup for all scenarios unless stated: NUM_THREADS=8, NUM_LANES=4, unit 2 target.
- Basic split: in_tmask=8'hFF, out_ready=all 1.
  - Unit 2 emits two batches: pid 0 (sop=1, eop=0, tmask 4'hF) then pid 1 (sop=0, eop=1, tmask 4'hF).
  - out_last_tid=7; in_ready pulses in cycle 2 only.
- Backpressure: BUF_SIZE=2, out_ready[2]=0, three 2-batch instructions.
  - After 2 pushes in_ready stays 0 and batch_idx holds.
  - Releasing out_ready drains in order, with the pid sequence 0,1,0,1,0,1.
- Channel independence: unit 1 stalled, instruction to unit 3 → unit 3 emits both batches; unit 1 buffer unchanged.
- Skip:
  - in_tmask=8'hF0 with DISPATCH_BATCH_SKIP_EN → single batch pid 1, sop=eop=1, last_tid=7.
  - Same stimulus without the macro → two batches, the first with tmask 4'h0.
- Reset mid-packet: assert reset after batch 0 is pushed → out_valid=0 immediately. After release the same instruction re-emits from pid 0.
- Bad unit: NUM_UNITS=3, in_unit=3 → in_ready=1 in the same cycle, no out_valid, err_bad_unit=1 until reset.
